// File: rtl/data_mem_responder.sv
// data_mem_responder: responder for the core's data-memory request channel.
// It grants requests and performs byte, halfword and word loads and stores
// against a word-organised RAM. After WAIT_STATES extra cycles it returns
// either load data or a write acknowledge. Misaligned accesses, out-of-range
// accesses and accesses with the reserved size code return an error response.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   data_req_i     request valid
//   data_addr_i    byte address
//   data_we_i      1 = store, 0 = load
//   data_size_i    00 byte, 01 half, 10 word, 11 reserved (error)
//   data_wdata_i   right-justified store data
//   data_gnt_o     request can be accepted this cycle (combinational)
//   data_rvalid_o  one-cycle response strobe (registered)
//   data_rdata_o   zero-extended load data, 0 unless a good load (registered)
//   data_err_o     error qualifier for the response (registered)
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned BYTES    = 4 * DEPTH_WORDS;
    localparam int unsigned AW       = $clog2(BYTES);
    localparam int unsigned IW       = AW - 2;
    localparam logic [31:0] SPAN     = 32'(BYTES);
    localparam logic [3:0]  CNT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [1:0]  SZ_BYTE  = 2'b00;
    localparam logic [1:0]  SZ_HALF  = 2'b01;
    localparam logic [1:0]  SZ_WORD  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [31:0] pend_rdata;
    logic        pend_err;
    logic        accept;

    logic [31:0] off;
    logic [IW-1:0] idx;
    logic [1:0]  lane;
    logic        req_err;
    logic [31:0] word_rd;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] resp_rdata;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    logic        rvalid_d;
    logic [31:0] rdata_d;
    logic        err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Grant is withheld while waiting and while reset is asserted.
    assign data_gnt_o = reset && (state != S_WAIT);
    assign accept     = data_req_i && data_gnt_o;

    // Address decode, error detection, lane selection and read formatting.
    always_comb begin
        off        = data_addr_i - BASE_ADDR;
        idx        = off[AW-1:2];
        lane       = off[1:0];
        req_err    = 1'b0;
        be         = 4'b0000;
        wdata_rep  = data_wdata_i;
        load_data  = 32'd0;
        word_rd    = mem[idx];
        shifted    = word_rd >> {lane, 3'b000};
        if (off >= SPAN) begin
            req_err = 1'b1;
        end
        case (data_size_i)
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{data_wdata_i[7:0]}};
                load_data = {24'd0, shifted[7:0]};
            end
            SZ_HALF: begin
                if (lane[0]) begin
                    req_err = 1'b1;
                end
                be        = 4'b0011 << lane;
                wdata_rep = {2{data_wdata_i[15:0]}};
                load_data = {16'd0, shifted[15:0]};
            end
            SZ_WORD: begin
                if (lane != 2'b00) begin
                    req_err = 1'b1;
                end
                be        = 4'b1111;
                load_data = word_rd;
            end
            default: req_err = 1'b1;
        endcase
        resp_rdata = (req_err || data_we_i) ? 32'd0 : load_data;
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (accept && data_we_i && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_RESP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Wait counter and response captured at acceptance.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt        <= 4'd0;
            pend_rdata <= 32'd0;
            pend_err   <= 1'b0;
        end else if (accept) begin
            cnt        <= CNT_LOAD;
            pend_rdata <= resp_rdata;
            pend_err   <= req_err;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Output decode: immediate response at zero wait states, else the
    // captured one on leaving WAIT.
    always_comb begin
        rvalid_d = 1'b0;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
        if (state == S_WAIT && cnt == 4'd0) begin
            rvalid_d = 1'b1;
            rdata_d  = pend_rdata;
            err_d    = pend_err;
        end else if (accept && WAIT_STATES == 0) begin
            rvalid_d = 1'b1;
            rdata_d  = resp_rdata;
            err_d    = req_err;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= 32'd0;
            data_err_o    <= 1'b0;
        end else begin
            data_rvalid_o <= rvalid_d;
            data_rdata_o  <= rdata_d;
            data_err_o    <= err_d;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: instance A (no wait states, base 0) and instance B
// (three wait states, base 0x8000_0000). Drivers push expected responses,
// per-instance monitors pop and compare data, error and arrival cycle.
`timescale 1ns/1ps
module tb_data_mem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_a, req_a, we_a, gnt_a, rvalid_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [1:0]  size_a;
    logic        reset_b, req_b, we_b, gnt_b, rvalid_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [1:0]  size_b;

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_a (
        .clock(clock), .reset(reset_a), .data_req_i(req_a), .data_addr_i(addr_a),
        .data_we_i(we_a), .data_size_i(size_a), .data_wdata_i(wdata_a),
        .data_gnt_o(gnt_a), .data_rvalid_o(rvalid_a), .data_rdata_o(rdata_a), .data_err_o(err_a));

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3)) u_b (
        .clock(clock), .reset(reset_b), .data_req_i(req_b), .data_addr_i(addr_b),
        .data_we_i(we_b), .data_size_i(size_b), .data_wdata_i(wdata_b),
        .data_gnt_o(gnt_b), .data_rvalid_o(rvalid_b), .data_rdata_o(rdata_b), .data_err_o(err_b));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   last_wait;
    int   last_acc;
    int   first_acc;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for instance A.
    always @(negedge clock) begin : mon_a
        exp_t e;
        if (cyc >= 2) begin
            if (rvalid_a === 1'b1) begin
                if (q_a.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL a_unexpected_rvalid: got rvalid=1 at cycle %0d, required no response", cyc);
                end else begin
                    e = q_a.pop_front();
                    check("a_rdata", rdata_a, e.rdata);
                    check("a_err", 32'(err_a), 32'(e.err));
                    check("a_latency", 32'(cyc), 32'(e.due));
                end
            end else begin
                check("a_idle_rvalid", 32'(rvalid_a), 32'd0);
                check("a_idle_rdata", rdata_a, 32'd0);
                check("a_idle_err", 32'(err_a), 32'd0);
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clock) begin : mon_b
        exp_t e;
        if (cyc >= 2) begin
            if (rvalid_b === 1'b1) begin
                if (q_b.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL b_unexpected_rvalid: got rvalid=1 at cycle %0d, required no response", cyc);
                end else begin
                    e = q_b.pop_front();
                    check("b_rdata", rdata_b, e.rdata);
                    check("b_err", 32'(err_b), 32'(e.err));
                    check("b_latency", 32'(cyc), 32'(e.due));
                end
            end else begin
                check("b_idle_rvalid", 32'(rvalid_b), 32'd0);
                check("b_idle_rdata", rdata_b, 32'd0);
                check("b_idle_err", 32'(err_b), 32'd0);
            end
        end
    end

    // Present a request, hold it until granted, and queue its expected response.
    task automatic issue(input bit b, input logic [31:0] addr, input logic we,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit push);
        exp_t e;
        int   t;
        @(negedge clock);
        if (b) begin
            req_b = 1'b1; addr_b = addr; we_b = we; size_b = size; wdata_b = wdata;
        end else begin
            req_a = 1'b1; addr_a = addr; we_a = we; size_a = size; wdata_a = wdata;
        end
        t = 0;
        while ((b ? gnt_b : gnt_a) !== 1'b1 && t <= 40) begin
            @(negedge clock);
            t++;
        end
        last_wait = t;
        if (t > 40) begin
            checks++;
            fails++;
            $display("FAIL grant_timeout: got no grant within 40 cycles for addr 0x%08h, required a grant", addr);
        end else begin
            last_acc = cyc;
            if (push) begin
                e.rdata = exp_rdata;
                e.err   = exp_err;
                e.due   = cyc + 1 + (b ? 3 : 0);
                if (b) q_b.push_back(e);
                else   q_a.push_back(e);
            end
        end
    endtask

    // Instance A never withholds grant outside reset.
    task automatic issue_a(input logic [31:0] addr, input logic we, input logic [1:0] size,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        issue(1'b0, addr, we, size, wdata, exp_rdata, exp_err, 1'b1);
        check("a_gnt_wait_cycles", 32'(last_wait), 32'd0);
    endtask

    task automatic idle(input bit b);
        @(negedge clock);
        if (b) req_b = 1'b0;
        else   req_a = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 30) begin
            @(negedge clock);
            t++;
        end
        if (t >= 30) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d/%0d responses outstanding, required 0", q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_a = 1'b0; req_a = 1'b0; addr_a = '0; we_a = 1'b0; size_a = 2'b10; wdata_a = '0;
        reset_b = 1'b0; req_b = 1'b0; addr_b = '0; we_b = 1'b0; size_b = 2'b10; wdata_b = '0;
        repeat (3) @(negedge clock);
        check("a_gnt_in_reset", 32'(gnt_a), 32'd0);
        check("b_gnt_in_reset", 32'(gnt_b), 32'd0);
        reset_a = 1'b1;
        reset_b = 1'b1;
        #1;
        check("a_gnt_after_reset", 32'(gnt_a), 32'd1);

        // Instance A: back-to-back traffic at zero wait states.
        issue_a(32'h10,  1'b1, 2'b10, 32'hDEADBEEF, 32'h0,        1'b0);
        issue_a(32'h10,  1'b0, 2'b10, 32'h0,        32'hDEADBEEF, 1'b0);
        issue_a(32'h13,  1'b1, 2'b00, 32'h123456AA, 32'h0,        1'b0);
        issue_a(32'h10,  1'b0, 2'b10, 32'h0,        32'hAAADBEEF, 1'b0);
        issue_a(32'h13,  1'b0, 2'b00, 32'h0,        32'h000000AA, 1'b0);
        issue_a(32'h12,  1'b0, 2'b01, 32'h0,        32'h0000AAAD, 1'b0);
        issue_a(32'h11,  1'b0, 2'b10, 32'h0,        32'h0,        1'b1);
        issue_a(32'h14,  1'b1, 2'b10, 32'h01234567, 32'h0,        1'b0);
        issue_a(32'h15,  1'b1, 2'b01, 32'h00005555, 32'h0,        1'b1);
        issue_a(32'h14,  1'b0, 2'b10, 32'h0,        32'h01234567, 1'b0);
        issue_a(32'h10,  1'b1, 2'b11, 32'hFFFFFFFF, 32'h0,        1'b1);
        issue_a(32'h10,  1'b0, 2'b10, 32'h0,        32'hAAADBEEF, 1'b0);
        issue_a(32'h12,  1'b0, 2'b10, 32'h0,        32'h0,        1'b1);
        issue_a(32'h1000, 1'b0, 2'b10, 32'h0,       32'h0,        1'b1);
        issue_a(32'hFFC, 1'b1, 2'b10, 32'hCAFEF00D, 32'h0,        1'b0);
        issue_a(32'hFFC, 1'b0, 2'b10, 32'h0,        32'hCAFEF00D, 1'b0);
        issue_a(32'h16,  1'b1, 2'b01, 32'h1234BEEF, 32'h0,        1'b0);
        issue_a(32'h14,  1'b0, 2'b10, 32'h0,        32'hBEEF4567, 1'b0);
        issue_a(32'h17,  1'b0, 2'b00, 32'h0,        32'h000000BE, 1'b0);
        idle(1'b0);
        drain();

        // Instance B: wait-state timing and grant withholding.
        issue(1'b1, 32'h8000_0000, 1'b1, 2'b10, 32'h11223344, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h8000_0000, 1'b0, 2'b10, 32'h0, 32'h11223344, 1'b0, 1'b1);
        @(negedge clock);
        req_b = 1'b0;
        check("b_gnt_wait1", 32'(gnt_b), 32'd0);
        @(negedge clock);
        check("b_gnt_wait2", 32'(gnt_b), 32'd0);
        @(negedge clock);
        check("b_gnt_wait3", 32'(gnt_b), 32'd0);
        @(negedge clock);
        check("b_gnt_resp", 32'(gnt_b), 32'd1);
        check("b_rvalid_resp", 32'(rvalid_b), 32'd1);
        issue(1'b1, 32'h7FFF_FFFC, 1'b0, 2'b10, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(1'b1, 32'h8000_0000, 1'b0, 2'b10, 32'h0, 32'h11223344, 1'b0, 1'b1);
        first_acc = last_acc;
        issue(1'b1, 32'h8000_0000, 1'b0, 2'b10, 32'h0, 32'h11223344, 1'b0, 1'b1);
        check("b_hold_spacing", 32'(last_acc - first_acc), 32'd4);
        idle(1'b1);
        drain();

        // Instance B: reset during WAIT drops the response but keeps the store.
        issue(1'b1, 32'h8000_0020, 1'b1, 2'b10, 32'h12345678, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        req_b   = 1'b0;
        reset_b = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("b_gnt_during_reset", 32'(gnt_b), 32'd0);
        end
        @(negedge clock);
        reset_b = 1'b1;
        issue(1'b1, 32'h8000_0020, 1'b0, 2'b10, 32'h0, 32'h12345678, 1'b0, 1'b1);
        check("b_first_accept_after_reset", 32'(last_wait), 32'd0);
        idle(1'b1);
        drain();
        repeat (6) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory request interface. Sits between the memory stage and a word-organised on-chip data RAM.
- Grants requests and executes byte, halfword and word loads and stores. Returns load data or a write acknowledge after a programmable number of wait states.
- Flags misaligned or out-of-range accesses with an error response.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; must be a power of two, at least 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- WAIT_STATES, 0: extra cycles between acceptance and response; range 0..15.

Ports:
- clock  in  1  single clock; rising-edge active.
- reset  in  1  synchronous, active-low reset.
- data_req_i  in  1  initiator presents a valid request.
- data_addr_i  in  32  byte address.
- data_we_i  in  1  1 = store, 0 = load.
- data_size_i  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (always an error).
- data_wdata_i  in  32  store data, right-justified: byte in [7:0], half in [15:0].
- data_gnt_o  out  1  responder can accept this cycle.
- data_rvalid_o  out  1  response valid; high for exactly one cycle per accepted request.
- data_rdata_o  out  32  load data, right-justified and zero-extended; 0 for stores and errors.
- data_err_o  out  1  error qualifier; meaningful only while data_rvalid_o is high.

Behaviour:
- Accept rule: a request is accepted on a rising edge where reset=1, data_req_i=1 and data_gnt_o=1. All request inputs are sampled on that edge.
- data_gnt_o is combinational from state. It is 1 in IDLE and in RESP, 0 in WAIT, and 0 while reset=0.
- FSM states: IDLE, WAIT, RESP.
  - Accept with WAIT_STATES=0: go to RESP.
  - Accept with WAIT_STATES>0: go to WAIT and load the counter with WAIT_STATES-1.
  - WAIT: the counter decrements each cycle; when it reaches 0, go to RESP.
  - RESP: if a new accept happens in this cycle (back-to-back), apply the same rule as from IDLE; otherwise go to IDLE.
- Latency: a request accepted at edge k has data_rvalid_o high in the cycle after edge k+WAIT_STATES. With WAIT_STATES=0 this is the cycle immediately after acceptance. Throughput is 1 access per cycle at WAIT_STATES=0, otherwise 1 per WAIT_STATES+1 cycles.
- Address decode:
  - off = data_addr_i - BASE_ADDR (32-bit subtraction).
  - In range when off < 4*DEPTH_WORDS; addr < BASE_ADDR wraps to a large off and is out of range.
  - Word index = off[log2(4*DEPTH_WORDS)-1:2].
- Alignment:
  - half requires off[0]=0.
  - word requires off[1:0]=00.
  - byte is always aligned.
- Error: any of misaligned, out of range, or size=11 produces a response with data_err_o=1 and data_rdata_o=0. An error store writes nothing.
- Store commit: a valid store is written on the acceptance edge, with byte lanes selected by off[1:0] and size. Unselected lanes are unchanged.
- Load: the RAM word is read on the acceptance edge. The selected byte or half is shifted to bit 0 and zero-extended; the core performs sign extension.
- Ordering: a load accepted after a store, including back-to-back at WAIT_STATES=0, returns the stored data.
- Output timing: data_rvalid_o, data_rdata_o and data_err_o are registered. data_rdata_o and data_err_o are 0 whenever data_rvalid_o is 0.
- Reset values (reset=0 at an edge): state IDLE, counter 0, data_rvalid_o 0, data_rdata_o 0, data_err_o 0, data_gnt_o 0. RAM contents are not reset.
- Reset mid-operation: the pending response is dropped and no rvalid is issued. A store already committed remains in RAM. The first accept is possible on the first edge after reset returns to 1.
- data_req_i=1 while data_gnt_o=0 is ignored; the initiator must hold the request until granted.

Test Plan:
- WAIT_STATES=0, after reset: SW addr 0x10, data 0xDEADBEEF; next cycle LW addr 0x10 -> store response rvalid=1, err=0, rdata=0; following cycle rvalid=1, rdata=0xDEADBEEF, and gnt stays 1 throughout.
- SB addr 0x13, data 0xAA, then LW addr 0x10 -> rdata=0xAAADBEEF. LB addr 0x13 -> rdata=0x000000AA. LH addr 0x12 -> rdata=0x0000AAAD.
- Errors: LW addr 0x11 -> err=1, rdata=0. SH addr 0x15 -> err=1, RAM unchanged. Size=11 -> err=1. With DEPTH_WORDS=1024, LW addr 0x1000 -> err=1.
- WAIT_STATES=3: LW accepted at edge k -> gnt=0 in the cycles after edges k..k+2, rvalid high only in the cycle after edge k+3, then gnt=1 again. A req held during WAIT is accepted only once gnt returns to 1.
- Reset during WAIT (WAIT_STATES=3): SW accepted, reset=0 one cycle later -> no rvalid issued; after reset, LW of the same address returns the stored data.
- BASE_ADDR=0x8000_0000: LW addr 0x7FFF_FFFC -> err=1. LW addr 0x8000_0000 -> err=0, word 0 returned.
